multicycle_ctrl: RTL

- Multicycle control FSM that drives the decode stage's control inputs (RF_WrEn, RF_WrData_sel, RF_B_sel) and the fetch, execute and memory stage enables.
- Sequences each instruction through FETCH/DECODE/EXEC/MEM/WB states.
- Performs a request/acknowledge handshake with the memory stage for every instruction or data access.
- Sits at the top level beside the datapath. Reads the held instruction word and the ALU zero flag.

---
 rtl/multicycle_ctrl.sv | 173 +++++++++++++++++
 1 files changed

// File: rtl/multicycle_ctrl.sv
// Multicycle control FSM: steps each instruction through fetch, decode, execute,
// memory and write-back, handshaking with the memory stage on every access.
module multicycle_ctrl #(
    parameter logic [3:0] ALU_ADD = 4'b0000,
    parameter logic [3:0] ALU_SUB = 4'b0001,
    parameter logic [3:0] ALU_AND = 4'b0010,
    parameter logic [3:0] ALU_OR  = 4'b0011
) (
    input  logic        Clk,
    input  logic        Reset,
    input  logic [31:0] Instr,
    input  logic        ALU_zero,
    input  logic        Mem_Ack,
    output logic        Mem_Req,
    output logic        Mem_WrEn,
    output logic        IR_WrEn,
    output logic        PC_LdEn,
    output logic        PC_sel,
    output logic        RF_WrEn,
    output logic        RF_WrData_sel,
    output logic        RF_B_sel,
    output logic        ALU_Bin_sel,
    output logic [3:0]  ALU_func,
    output logic        Instr_done,
    output logic        Illegal
);

    localparam logic [5:0] OP_R    = 6'b100000;
    localparam logic [5:0] OP_ADDI = 6'b110000;
    localparam logic [5:0] OP_ANDI = 6'b110010;
    localparam logic [5:0] OP_ORI  = 6'b110011;
    localparam logic [5:0] OP_LW   = 6'b001111;
    localparam logic [5:0] OP_SW   = 6'b011111;
    localparam logic [5:0] OP_BEQ  = 6'b000000;
    localparam logic [5:0] OP_B    = 6'b111111;

    typedef enum logic [3:0] {
        FETCH, DECODE, EXEC_R, EXEC_I, WB_ALU, MEM_ADDR,
        MEM_RD, WB_MEM, MEM_WR, EXEC_BR, BR_TAKE
    } state_t;

    state_t     state, next_state;
    logic       illegal_q;
    logic [5:0] opcode;
    logic       is_r, is_i, is_lw, is_sw, is_beq, is_b, is_bad;
    logic [3:0] i_func;
    logic       unused_instr_bits;

    assign opcode            = Instr[31:26];
    assign unused_instr_bits = ^Instr[25:4];

    assign is_r   = (opcode == OP_R);
    assign is_i   = (opcode == OP_ADDI) || (opcode == OP_ANDI) || (opcode == OP_ORI);
    assign is_lw  = (opcode == OP_LW);
    assign is_sw  = (opcode == OP_SW);
    assign is_beq = (opcode == OP_BEQ);
    assign is_b   = (opcode == OP_B);
    assign is_bad = !(is_r || is_i || is_lw || is_sw || is_beq || is_b);

    always_comb begin
        i_func = ALU_ADD;
        if (opcode == OP_ANDI)
            i_func = ALU_AND;
        else if (opcode == OP_ORI)
            i_func = ALU_OR;
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state     <= FETCH;
            illegal_q <= 1'b0;
        end else begin
            state <= next_state;
            if (state == DECODE && is_bad)
                illegal_q <= 1'b1;
        end
    end

    always_comb begin
        next_state = state;
        unique case (state)
            FETCH:    if (Mem_Ack) next_state = DECODE;
            DECODE: begin
                if (is_r)                next_state = EXEC_R;
                else if (is_i)           next_state = EXEC_I;
                else if (is_lw || is_sw) next_state = MEM_ADDR;
                else if (is_beq)         next_state = EXEC_BR;
                else if (is_b)           next_state = BR_TAKE;
                else                     next_state = FETCH;
            end
            EXEC_R:   next_state = WB_ALU;
            EXEC_I:   next_state = WB_ALU;
            WB_ALU:   next_state = FETCH;
            MEM_ADDR: next_state = is_lw ? MEM_RD : MEM_WR;
            MEM_RD:   if (Mem_Ack) next_state = WB_MEM;
            WB_MEM:   next_state = FETCH;
            MEM_WR:   if (Mem_Ack) next_state = FETCH;
            EXEC_BR:  next_state = ALU_zero ? BR_TAKE : FETCH;
            BR_TAKE:  next_state = FETCH;
            default:  next_state = FETCH;
        endcase
    end

    // Reset forces every output low combinationally, so an in-flight request drops at once.
    always_comb begin
        Mem_Req       = 1'b0;
        Mem_WrEn      = 1'b0;
        IR_WrEn       = 1'b0;
        PC_LdEn       = 1'b0;
        PC_sel        = 1'b0;
        RF_WrEn       = 1'b0;
        RF_WrData_sel = 1'b0;
        RF_B_sel      = 1'b0;
        ALU_Bin_sel   = 1'b0;
        ALU_func      = '0;
        Instr_done    = 1'b0;
        Illegal       = 1'b0;
        if (!Reset) begin
            RF_B_sel = is_sw || is_beq;
            Illegal  = illegal_q;
            unique case (state)
                FETCH: begin
                    Mem_Req = 1'b1;
                    IR_WrEn = Mem_Ack;
                end
                DECODE: begin
                    PC_LdEn    = 1'b1;
                    Instr_done = is_bad;
                end
                EXEC_R:   ALU_func = Instr[3:0];
                EXEC_I: begin
                    ALU_Bin_sel = 1'b1;
                    ALU_func    = i_func;
                end
                WB_ALU: begin
                    ALU_func   = is_r ? Instr[3:0] : i_func;
                    RF_WrEn    = 1'b1;
                    Instr_done = 1'b1;
                end
                MEM_ADDR: begin
                    ALU_Bin_sel = 1'b1;
                    ALU_func    = ALU_ADD;
                end
                MEM_RD: begin
                    Mem_Req     = 1'b1;
                    ALU_Bin_sel = 1'b1;
                    ALU_func    = ALU_ADD;
                end
                WB_MEM: begin
                    RF_WrEn       = 1'b1;
                    RF_WrData_sel = 1'b1;
                    Instr_done    = 1'b1;
                end
                MEM_WR: begin
                    Mem_Req    = 1'b1;
                    Mem_WrEn   = 1'b1;
                    Instr_done = Mem_Ack;
                end
                EXEC_BR: begin
                    ALU_func   = ALU_SUB;
                    Instr_done = !ALU_zero;
                end
                BR_TAKE: begin
                    PC_LdEn    = 1'b1;
                    PC_sel     = 1'b1;
                    Instr_done = 1'b1;
                end
                default: ;
            endcase
        end
    end

endmodule
